random_display: RTL and testbench

Consumer stage for the 4-bit LFSR nibble on the Max10 board. On a debounced press of a pushbutton it runs a "dice roll": the 7-segment digit shows a fresh random nibble every step for a fixed number of steps. It then freezes on the last value and holds it until the next press. It drives one active-low 7-segment digit and exports the held value, a busy flag and a completion pulse.

---
 rtl/random_display.sv | 181 ++++++++++++++++++
 tb/tb_random_display.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/random_display.sv
`default_nettype none
// ============================================================================
// Module   : random_display
// Brief    : Debounced pushbutton starts a "dice roll" of LFSR nibbles shown
//            on one active-low 7-segment digit, then holds the last value.
//            Optional DP-lit-while-rolling: define RANDOM_DISPLAY_DP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module random_display #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int STEP_CYCLES     = 2500000,
   parameter int ROLL_STEPS      = 16
) (
   input  logic       clk_in,
   input  logic       reset_n_in,
   input  logic [3:0] rand_in,
   input  logic       btn_n_in,
   output logic [7:0] seg_out,
   output logic [3:0] value_out,
   output logic       busy_out,
   output logic       done_out
);

   localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int c_STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int c_ROLL_W = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;

   localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
   localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYCLES - 1);
   localparam logic [c_STEP_W-1:0] c_STEP_ONE  = c_STEP_W'(1);
   localparam logic [c_ROLL_W-1:0] c_ROLL_LAST = c_ROLL_W'(ROLL_STEPS - 1);
   localparam logic [c_ROLL_W-1:0] c_ROLL_ONE  = c_ROLL_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ROLL = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Button synchronizer and debouncer
   // ------------------------------------------------------------------------
   logic              r_sync_1;
   logic              r_sync_2;
   logic              r_btn_db;
   logic [c_DB_W-1:0] r_db_cnt;
   logic              w_differ;
   logic              w_accept;
   logic              w_press;

   assign w_differ = (r_sync_2 != r_btn_db);
   assign w_accept = w_differ && (r_db_cnt == c_DB_LAST);
   // Accepting while the debounced level is still high means it falls now.
   assign w_press  = w_accept && r_btn_db;

   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         r_sync_1 <= 1'b1;
         r_sync_2 <= 1'b1;
         r_btn_db <= 1'b1;
         r_db_cnt <= '0;
      end else begin
         r_sync_1 <= btn_n_in;
         r_sync_2 <= r_sync_1;
         if (!w_differ) begin
            r_db_cnt <= '0;
         end else if (w_accept) begin
            r_btn_db <= r_sync_2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + c_DB_ONE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Roll sequencer
   // ------------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_next;
   logic [c_STEP_W-1:0] r_timer;
   logic [c_STEP_W-1:0] w_timer_next;
   logic [c_ROLL_W-1:0] r_step;
   logic [c_ROLL_W-1:0] w_step_next;
   logic [3:0]          r_value;
   logic [3:0]          w_value_next;
   logic                r_done;
   logic                w_done_next;

   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_step  <= '0;
         r_value <= 4'h0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_timer <= w_timer_next;
         r_step  <= w_step_next;
         r_value <= w_value_next;
         r_done  <= w_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_timer_next = r_timer;
      w_step_next  = r_step;
      w_value_next = r_value;
      w_done_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_press) begin
               w_state_next = ST_ROLL;
               w_timer_next = '0;
               w_step_next  = '0;
            end
         end
         ST_ROLL: begin
            // Presses seen here are deliberately dropped, not queued.
            if (r_timer == c_STEP_LAST) begin
               w_timer_next = '0;
               w_value_next = rand_in;
               if (r_step == c_ROLL_LAST) begin
                  w_state_next = ST_IDLE;
                  w_step_next  = '0;
                  w_done_next  = 1'b1;
               end else begin
                  w_step_next = r_step + c_ROLL_ONE;
               end
            end else begin
               w_timer_next = r_timer + c_STEP_ONE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign busy_out  = (r_state == ST_ROLL);
   assign done_out  = r_done;
   assign value_out = r_value;

   // ------------------------------------------------------------------------
   // 7-segment decode, active-low gfedcba
   // ------------------------------------------------------------------------
   logic [6:0] w_seg;

   always_comb begin
      w_seg = 7'h7F;
      case (r_value)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         4'hF: w_seg = 7'h0E;
         default: w_seg = 7'h7F;
      endcase
   end

`ifdef RANDOM_DISPLAY_DP_EN
   assign seg_out = {~busy_out, w_seg};
`else
   assign seg_out = {1'b1, w_seg};
`endif

endmodule
`default_nettype wire

// File: tb/tb_random_display.sv
`default_nettype none
// Testbench for random_display: randomized and directed button/reset stimulus,
// behavioural reference model feeding a scoreboard queue checked every cycle.
module tb_random_display;

   localparam int DEB   = 4;
   localparam int STEP  = 3;
   localparam int ROLLS = 2;

   logic       clk_in = 1'b0;
   logic       reset_n_in = 1'b0;
   logic [3:0] rand_in = 4'h0;
   logic       btn_n_in = 1'b1;
   logic [7:0] seg_out;
   logic [3:0] value_out;
   logic       busy_out;
   logic       done_out;

   random_display #(
      .DEBOUNCE_CYCLES(DEB),
      .STEP_CYCLES    (STEP),
      .ROLL_STEPS     (ROLLS)
   ) dut (
      .clk_in    (clk_in),
      .reset_n_in(reset_n_in),
      .rand_in   (rand_in),
      .btn_n_in  (btn_n_in),
      .seg_out   (seg_out),
      .value_out (value_out),
      .busy_out  (busy_out),
      .done_out  (done_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [3:0] value;
      logic [7:0] seg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   dut_done_cnt = 0;
   int   cycle_n = 0;

   logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference model state
   logic       m_s1 = 1'b1;
   logic       m_s2 = 1'b1;
   logic       m_db = 1'b1;
   int         m_run = 0;
   logic       m_rolling = 1'b0;
   int         m_start = 0;
   logic [3:0] m_value = 4'h0;
   logic       m_done = 1'b0;
   int         m_edge = 0;
   int         m_done_cnt = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cycle_n, act, req);
      end
   endtask

   function automatic logic [7:0] seg_of(input logic [3:0] v, input logic busy);
      logic [7:0] s;
      s = seg_tbl[v];
`ifdef RANDOM_DISPLAY_DP_EN
      s[7] = ~busy;
`else
      s[7] = 1'b1;
`endif
      return s;
   endfunction

   // One clock of stimulus; the model predicts the outputs after the next edge.
   task automatic step(input logic rst_n, input logic btn, input logic [3:0] rnd);
      logic lvl;
      logic press;
      int   elapsed;
      exp_t e;
      @(negedge clk_in);
      reset_n_in = rst_n;
      btn_n_in   = btn;
      rand_in    = rnd;
      m_edge++;
      m_done = 1'b0;
      if (!rst_n) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_db = 1'b1; m_run = 0;
         m_rolling = 1'b0; m_value = 4'h0;
      end else begin
         lvl   = m_s2;
         m_s2  = m_s1;
         m_s1  = btn;
         press = 1'b0;
         if (lvl != m_db) begin
            m_run++;
            if (m_run == DEB) begin
               m_db  = lvl;
               m_run = 0;
               press = (lvl == 1'b0);
            end
         end else begin
            m_run = 0;
         end
         if (m_rolling) begin
            elapsed = m_edge - m_start;
            if (elapsed % STEP == 0) begin
               m_value = rnd;
               if (elapsed / STEP == ROLLS) begin
                  m_rolling = 1'b0;
                  m_done    = 1'b1;
                  m_done_cnt++;
               end
            end
         end else if (press) begin
            m_rolling = 1'b1;
            m_start   = m_edge;
         end
      end
      e.busy  = m_rolling;
      e.done  = m_done;
      e.value = m_value;
      e.seg   = seg_of(m_value, m_rolling);
      exp_q.push_back(e);
   endtask

   task automatic hold(input int n, input logic rst_n, input logic btn, input logic [3:0] rnd);
      for (int i = 0; i < n; i++) step(rst_n, btn, rnd);
   endtask

   // Monitor: compares DUT outputs after every edge against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         cycle_n++;
         if (done_out === 1'b1) dut_done_cnt++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy",  {7'd0, busy_out}, {7'd0, e.busy});
            chk("done",  {7'd0, done_out}, {7'd0, e.done});
            chk("value", {4'd0, value_out}, {4'd0, e.value});
            chk("seg",   seg_out, e.seg);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset
      hold(2, 1'b0, 1'b1, 4'h5);
      hold(3, 1'b1, 1'b1, 4'h3);
      // Glitch shorter than the debounce window
      hold(3, 1'b1, 1'b0, 4'h9);
      hold(10, 1'b1, 1'b1, 4'h9);
      // Full roll with a fixed nibble
      hold(16, 1'b1, 1'b0, 4'h7);
      hold(10, 1'b1, 1'b1, 4'h7);
      // Toggling during a roll, then a fresh press ending on 'A'
      hold(6, 1'b1, 1'b0, 4'h2);
      hold(2, 1'b1, 1'b1, 4'h2);
      hold(3, 1'b1, 1'b0, 4'h2);
      hold(10, 1'b1, 1'b1, 4'h2);
      hold(14, 1'b1, 1'b0, 4'hA);
      hold(10, 1'b1, 1'b1, 4'hA);
      // Reset in the middle of a roll
      hold(8, 1'b1, 1'b0, 4'hC);
      step(1'b0, 1'b0, 4'hC);
      hold(12, 1'b1, 1'b1, 4'hC);
      // Randomized button levels, hold lengths, nibbles and occasional resets
      for (int s = 0; s < 300; s++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++)
            step(($urandom_range(0, 99) != 0), lvl, 4'($urandom));
      end
      hold(20, 1'b1, 1'b1, 4'h1);
      @(posedge clk_in);
      #3;
      chk("queue_drained", 8'(exp_q.size()), 8'd0);
      checks++;
      if (dut_done_cnt != m_done_cnt) begin
         errors++;
         $display("FAIL done_count: got %0d, expected %0d", dut_done_cnt, m_done_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
